vector_tx_scheduler: RTL and testbench
======================================

Name: vector_tx_scheduler

Overview:
- Shares one AXI-stream serializer between N_REQ requesters. Each requester offers a fixed-width byte vector.
- A round-robin arbiter grants one requester and latches its vector. The vector then goes out as one AXIS packet of VEC_BYTES/AXIS_BYTES beats, with tlast on the final beat and tid carrying the source index.
- Sits between status/telemetry producers and a shared AXIS sink such as a UART or DMA.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- VEC_BYTES, 4, bytes per request vector; must be a multiple of AXIS_BYTES (static assert)
- AXIS_BYTES, 1, bytes per AXIS beat
- MSB_FIRST, 0, 1 = most-significant AXIS_BYTES slice sent first; 0 = least-significant first

Ports:
- clk  in  1  single clock
- areset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  bit i = requester i has a vector pending
- req_ready  out  N_REQ  bit i = vector i accepted this cycle (transfer on valid&ready)
- req_vec  in  N_REQ*VEC_BYTES*8  flattened vectors; requester i occupies bits [(i+1)*VEC_BYTES*8-1 : i*VEC_BYTES*8]
- axis_tdata  out  AXIS_BYTES*8  beat data
- axis_tvalid  out  1  beat valid
- axis_tready  in  1  sink ready
- axis_tlast  out  1  final beat of packet
- axis_tkeep  out  AXIS_BYTES  all ones
- axis_tid  out  IDW  source requester index; IDW = max(1, clog2(N_REQ))
- busy  out  1  high in SEND

Behaviour:
- Derived constants: BEATS = VEC_BYTES/AXIS_BYTES; CTR_W = max(1, clog2(BEATS)).
- On areset: state=IDLE, rr_ptr=0, beat ctr=start slice, axis_tvalid=0, axis_tlast=0, axis_tdata=0, axis_tid=0, req_ready=0, busy=0. Reset takes effect immediately, independent of clk.
- State IDLE:
  - Grant = first asserted req_valid bit at or above rr_ptr, wrapping modulo N_REQ.
  - req_ready = one-hot of the grant; combinational from req_valid and rr_ptr; at most one bit set.
  - On accept: latch req_vec slice and grant index; rr_ptr <= grant+1 mod N_REQ; ctr <= start slice; go to SEND.
  - No req_valid: stay in IDLE, req_ready=0.
- State SEND:
  - axis_tvalid=1.
  - axis_tdata = latched slice selected by ctr: slice 0 (LSB) first when MSB_FIRST=0, slice BEATS-1 first when MSB_FIRST=1.
  - axis_tid = latched index; axis_tlast=1 only on final slice.
  - On axis_tvalid&axis_tready:
    - not last: advance ctr.
    - last: go to IDLE.
  - tready low: tdata, tlast and tid hold stable.
  - req_ready=0 throughout SEND (unless the optional feature is enabled).
- Latency: accept at edge N; first beat valid in the cycle after edge N. Packet = BEATS cycles at full tready. Without the option, one IDLE cycle separates packets.
- BEATS=1: every beat has tlast=1; ctr unused, held at 0.
- Fairness: a requester holding req_valid is served within N_REQ packets.
- A requester deasserting req_valid before grant is simply skipped; no penalty.
- The latched vector is immune to req_vec changes after accept.
- areset mid-packet: packet abandoned without tlast; the accepted request is not replayed.
- All state and output registers are flops; req_ready is the only combinational output.

Optional Feature:
- Macro: VECTOR_TX_SCHEDULER_ZERO_BUBBLE_EN.
- Defined: in SEND, on the last-beat handshake (tvalid&tready&tlast), the arbiter also evaluates.
  - req_ready may assert in that same cycle, combinationally dependent on axis_tready.
  - On accept: load the new vector and ctr, stay in SEND. The next cycle is beat 0 of the new packet with no gap.
  - No request pending: go to IDLE.
- Undefined: req_ready is only asserted in IDLE; one-cycle gap between packets; no path from axis_tready to req_ready.

Decomposition:
- Package vector_tx_scheduler_pkg holds:
  - state enum {IDLE, SEND};
  - a function computing IDW;
  - a function returning the rr-grant one-hot from (req, ptr).
- One natural sub-module: rr_arbiter (N parameter).
  - Inputs: req, ptr, en.
  - Outputs: grant_onehot, grant_idx.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- VEC_BYTES=4, AXIS_BYTES=1, MSB_FIRST=0; req_valid=0001, req_vec[0]=0xA1B2C3D4, tready=1 -> beats D4,C3,B2,A1; tlast on 4th beat only; tid=0; req_ready[0] high exactly one cycle.
- Same config, MSB_FIRST=1 -> beats A1,B2,C3,D4.
- All four req_valid held high -> packets with tid 0,1,2,3,0; one IDLE cycle between packets (macro off); zero gap with macro on.
- tready toggled 1,0,0,1 during packet -> tdata, tlast and tid constant while tready=0; no beat skipped or duplicated.
- Change req_vec[1] from 0x11111111 to 0x22222222 the cycle after accept -> all beats of that packet are 0x11.
- areset pulsed during beat 2 -> tvalid drops immediately; after release IDLE with rr_ptr=0; next grant goes to lowest pending index.

Source files
------------

// File: rtl/vector_tx_scheduler_pkg.sv
// Shared types and helpers for vector_tx_scheduler: FSM state, tid width and round-robin grant.
package vector_tx_scheduler_pkg;

    localparam int unsigned MAX_REQ = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int unsigned calc_idw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot of the first set req bit at or above ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                     input logic [3:0]         ptr,
                                                     input logic [4:0]         n);
        logic [MAX_REQ-1:0] g;
        logic [4:0]         idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= n) idx = idx - n;
            if ((5'(k) < n) && (g == '0) && req[idx[3:0]]) g[idx[3:0]] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/vector_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer register lives in the parent.
module vector_tx_scheduler_rr_arbiter
    import vector_tx_scheduler_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = calc_idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant_onehot,
    output logic [IDW-1:0] grant_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] grant_ext;
    logic               unused_grant_hi;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        grant_ext        = rr_grant(req_ext, 4'(ptr), 5'(N));
        grant_onehot     = '0;
        grant_idx        = '0;
        for (int i = 0; i < N; i++) begin
            if (en && grant_ext[i]) begin
                grant_onehot[i] = 1'b1;
                grant_idx       = IDW'(i);
            end
        end
    end

    // Bits above N are always zero since req_ext is zero-padded.
    assign unused_grant_hi = ^grant_ext;

endmodule

// File: rtl/vector_tx_scheduler.sv
// Round-robin share of one AXIS serializer among N_REQ byte-vector requesters.
// Define VECTOR_TX_SCHEDULER_ZERO_BUBBLE_EN to re-arbitrate on the last beat with no idle gap.
module vector_tx_scheduler
    import vector_tx_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned VEC_BYTES  = 4,
    parameter int unsigned AXIS_BYTES = 1,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*VEC_BYTES*8-1:0]  req_vec,
    output logic [AXIS_BYTES*8-1:0]       axis_tdata,
    output logic                          axis_tvalid,
    input  logic                          axis_tready,
    output logic                          axis_tlast,
    output logic [AXIS_BYTES-1:0]         axis_tkeep,
    output logic [calc_idw(N_REQ)-1:0]    axis_tid,
    output logic                          busy
);

    localparam int unsigned IDW       = calc_idw(N_REQ);
    localparam int unsigned VEC_W     = VEC_BYTES * 8;
    localparam int unsigned BEAT_W    = AXIS_BYTES * 8;
    localparam int unsigned BEATS     = VEC_BYTES / AXIS_BYTES;
    localparam int unsigned CTR_W     = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam int unsigned NSLOT     = 1 << CTR_W;
    localparam int unsigned START_OFS = (MSB_FIRST ? BEATS - 1 : 0) * BEAT_W;
    localparam logic [CTR_W-1:0] START = MSB_FIRST ? CTR_W'(BEATS - 1) : '0;
    localparam logic [CTR_W-1:0] LAST  = MSB_FIRST ? '0 : CTR_W'(BEATS - 1);

    if ((VEC_BYTES == 0) || (AXIS_BYTES == 0) || (VEC_BYTES % AXIS_BYTES != 0)) begin : g_bad_bytes
        $error("VEC_BYTES must be a nonzero multiple of AXIS_BYTES");
    end
    if ((N_REQ < 2) || (N_REQ > MAX_REQ)) begin : g_bad_nreq
        $error("N_REQ must be in 2..16");
    end

    state_e              state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      rr_ptr_nxt;
    logic [CTR_W-1:0]    ctr_q;
    logic [CTR_W-1:0]    ctr_nxt;
    logic [VEC_W-1:0]    vec_q;
    logic [BEAT_W-1:0]   tdata_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [IDW-1:0]      tid_q;
    logic                busy_q;

    logic                arb_en;
    logic                accept;
    logic [N_REQ-1:0]    grant_onehot;
    logic [IDW-1:0]      grant_idx;
    logic [VEC_W-1:0]    grant_vec;
    logic [BEAT_W-1:0]   vec_slice [NSLOT];

`ifdef VECTOR_TX_SCHEDULER_ZERO_BUBBLE_EN
    assign arb_en = !areset &&
                    ((state_q == IDLE) || ((state_q == SEND) && axis_tready && tlast_q));
`else
    assign arb_en = !areset && (state_q == IDLE);
`endif

    vector_tx_scheduler_rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_arb (
        .req          (req_valid),
        .ptr          (rr_ptr_q),
        .en           (arb_en),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign req_ready  = grant_onehot;
    assign accept     = |grant_onehot;
    assign rr_ptr_nxt = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign ctr_nxt    = MSB_FIRST ? ctr_q - 1'b1 : ctr_q + 1'b1;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_onehot[i]) grant_vec = req_vec[i*VEC_W +: VEC_W];
        end
    end

    // Pad to a power of two so ctr can index the slice table without range checks.
    for (genvar s = 0; s < NSLOT; s++) begin : g_slice
        if (s < BEATS) begin : g_used
            assign vec_slice[s] = vec_q[s*BEAT_W +: BEAT_W];
        end else begin : g_pad
            assign vec_slice[s] = '0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            ctr_q    <= START;
            vec_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            // Either from IDLE or, with zero-bubble, on the last-beat handshake.
            state_q  <= SEND;
            rr_ptr_q <= rr_ptr_nxt;
            ctr_q    <= START;
            vec_q    <= grant_vec;
            tdata_q  <= grant_vec[START_OFS +: BEAT_W];
            tvalid_q <= 1'b1;
            tlast_q  <= (BEATS == 1);
            tid_q    <= grant_idx;
            busy_q   <= 1'b1;
        end else if ((state_q == SEND) && axis_tready) begin
            if (tlast_q) begin
                state_q  <= IDLE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                ctr_q   <= ctr_nxt;
                tdata_q <= vec_slice[ctr_nxt];
                tlast_q <= (ctr_nxt == LAST);
            end
        end
    end

    assign axis_tdata  = tdata_q;
    assign axis_tvalid = tvalid_q;
    assign axis_tlast  = tlast_q;
    assign axis_tid    = tid_q;
    assign axis_tkeep  = '1;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vector_tx_scheduler.sv
// Directed bench: two scheduler instances (LSB-first and MSB-first) driven by shared stimulus.
module tb_vector_tx_scheduler;

    logic         clk = 1'b0;
    logic         areset;
    logic [3:0]   req_valid;
    logic [127:0] req_vec;
    logic         axis_tready;

    logic [3:0] rdy_a, rdy_b;
    logic [7:0] td_a, td_b;
    logic       tv_a, tv_b, tl_a, tl_b, busy_a, busy_b;
    logic [0:0] tk_a, tk_b;
    logic [1:0] tid_a, tid_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_lsb [4];

    vector_tx_scheduler #(
        .N_REQ(4), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b0)
    ) dut_a (
        .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(rdy_a),
        .req_vec(req_vec), .axis_tdata(td_a), .axis_tvalid(tv_a), .axis_tready(axis_tready),
        .axis_tlast(tl_a), .axis_tkeep(tk_a), .axis_tid(tid_a), .busy(busy_a)
    );

    vector_tx_scheduler #(
        .N_REQ(4), .VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1'b1)
    ) dut_b (
        .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(rdy_b),
        .req_vec(req_vec), .axis_tdata(td_b), .axis_tvalid(tv_b), .axis_tready(axis_tready),
        .axis_tlast(tl_b), .axis_tkeep(tk_b), .axis_tid(tid_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_lsb[0] = 8'hD4; exp_lsb[1] = 8'hC3; exp_lsb[2] = 8'hB2; exp_lsb[3] = 8'hA1;
        areset      = 1'b1;
        req_valid   = 4'b0001;
        req_vec     = '0;
        axis_tready = 1'b1;
        #12;
        // Reset state, with a request pending that must not be granted.
        chk("rst_tvalid", 32'(tv_a), 32'(1'b0));
        chk("rst_tlast",  32'(tl_a), 32'(1'b0));
        chk("rst_tdata",  32'(td_a), 32'(8'h00));
        chk("rst_tid",    32'(tid_a), 32'(2'd0));
        chk("rst_ready",  32'(rdy_a), 32'(4'b0000));
        chk("rst_busy",   32'(busy_a), 32'(1'b0));
        chk("rst_tkeep",  32'(tk_a), 32'(1'b1));
        req_valid = 4'b0000;
        #1 areset = 1'b0;
        tick();
        chk("idle_noreq_ready", 32'(rdy_a), 32'(4'b0000));

        // Single packet, LSB-first on dut_a and MSB-first on dut_b.
        req_vec[31:0] = 32'hA1B2C3D4;
        req_valid     = 4'b0001;
        #1;
        chk("t1_ready_a", 32'(rdy_a), 32'(4'b0001));
        chk("t1_ready_b", 32'(rdy_b), 32'(4'b0001));
        tick();
        req_valid = 4'b0000;
        #1;
        chk("t1_ready_drop", 32'(rdy_a), 32'(4'b0000));
        for (int b = 0; b < 4; b++) begin
            chk("t1_tvalid", 32'(tv_a), 32'(1'b1));
            chk("t1_tdata_lsb", 32'(td_a), 32'(exp_lsb[b]));
            chk("t1_tdata_msb", 32'(td_b), 32'(exp_lsb[3-b]));
            chk("t1_tlast_a", 32'(tl_a), 32'(b == 3));
            chk("t1_tlast_b", 32'(tl_b), 32'(b == 3));
            chk("t1_tid", 32'(tid_a), 32'(2'd0));
            chk("t1_busy", 32'(busy_a), 32'(1'b1));
            tick();
        end
        chk("t1_end_tvalid", 32'(tv_a), 32'(1'b0));
        chk("t1_end_busy_b", 32'(busy_b), 32'(1'b0));

        // Round robin from a fresh pointer with all requesters asserted.
        areset = 1'b1;
        #1 areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_vec[i*32 +: 32] = {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
        end
        req_valid = 4'b1111;
        #1;
        chk("t2_ready_onehot", 32'(rdy_a), 32'(4'b0001));
        tick();
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 4; b++) begin
                chk("t2_tvalid", 32'(tv_a), 32'(1'b1));
                chk("t2_tid", 32'(tid_a), 32'(p % 4));
                chk("t2_tdata_lsb", 32'(td_a), 32'(8'((p % 4)*4 + b)));
                chk("t2_tdata_msb", 32'(td_b), 32'(8'((p % 4)*4 + 3 - b)));
                chk("t2_tlast", 32'(tl_a), 32'(b == 3));
                if (p == 4 && b == 3) req_valid = 4'b0000;
                tick();
            end
`ifndef VECTOR_TX_SCHEDULER_ZERO_BUBBLE_EN
            if (p < 4) begin
                chk("t2_gap_tvalid", 32'(tv_a), 32'(1'b0));
                chk("t2_gap_ready", 32'(rdy_a), 32'(4'b0001 << ((p + 1) % 4)));
                tick();
            end
`endif
        end
        chk("t2_end_tvalid", 32'(tv_a), 32'(1'b0));

        // Backpressure: tready 1,0,0,1 must hold beat 1 steady.
        req_vec[95:64] = 32'h44332211;
        req_valid      = 4'b0100;
        tick();
        req_valid = 4'b0000;
        chk("t3_b0", 32'(td_a), 32'(8'h11));
        tick();
        chk("t3_b1", 32'(td_a), 32'(8'h22));
        axis_tready = 1'b0;
        tick();
        chk("t3_hold1_tdata", 32'(td_a), 32'(8'h22));
        chk("t3_hold1_tlast", 32'(tl_a), 32'(1'b0));
        chk("t3_hold1_tid", 32'(tid_a), 32'(2'd2));
        chk("t3_hold1_tvalid", 32'(tv_a), 32'(1'b1));
        tick();
        chk("t3_hold2_tdata", 32'(td_a), 32'(8'h22));
        chk("t3_hold2_tid", 32'(tid_a), 32'(2'd2));
        axis_tready = 1'b1;
        tick();
        chk("t3_b2", 32'(td_a), 32'(8'h33));
        chk("t3_b2_tlast", 32'(tl_a), 32'(1'b0));
        tick();
        chk("t3_b3", 32'(td_a), 32'(8'h44));
        chk("t3_b3_tlast", 32'(tl_a), 32'(1'b1));
        tick();
        chk("t3_end_tvalid", 32'(tv_a), 32'(1'b0));

        // Latched vector immune to req_vec change after accept; also wraps the pointer.
        req_vec[63:32] = 32'h11111111;
        req_valid      = 4'b0010;
        #1;
        chk("t4_ready", 32'(rdy_a), 32'(4'b0010));
        tick();
        req_vec[63:32] = 32'h22222222;
        req_valid      = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            chk("t4_tdata", 32'(td_a), 32'(8'h11));
            chk("t4_tid", 32'(tid_a), 32'(2'd1));
            tick();
        end
        chk("t4_end_tvalid", 32'(tv_a), 32'(1'b0));

        // Asynchronous reset during beat 2 abandons the packet.
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        chk("t5_b0", 32'(td_a), 32'(8'd12));
        tick();
        tick();
        chk("t5_b2", 32'(td_a), 32'(8'd14));
        #2 areset = 1'b1;
        #1;
        chk("t5_rst_tvalid", 32'(tv_a), 32'(1'b0));
        chk("t5_rst_tlast", 32'(tl_a), 32'(1'b0));
        chk("t5_rst_busy", 32'(busy_a), 32'(1'b0));
        chk("t5_rst_tdata", 32'(td_a), 32'(8'h00));
        #1 areset = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("t5_lowest_ready", 32'(rdy_a), 32'(4'b0010));
        tick();
        req_valid = 4'b0000;
        chk("t5_post_tid", 32'(tid_a), 32'(2'd1));
        chk("t5_post_tdata", 32'(td_a), 32'(8'h22));
        chk("t5_post_tvalid", 32'(tv_a), 32'(1'b1));
        for (int b = 0; b < 4; b++) tick();
        chk("t5_end_tvalid", 32'(tv_a), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
